// File: rtl/spi_debug_pkg.sv
// Shared types and constants for the SPI debug console transmitter.
// Contents: shift FSM state encoding and the default SCK half-period divider.
// Imported by spi_debug_tx and spi_debug_fifo.
package spi_debug_pkg;

  // Shift FSM states: IDLE waits for data, LOW/HIGH are the two SCK phases.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  // clk cycles per SCK half-period unless overridden at instantiation.
  localparam int CLK_DIV_DEFAULT = 4;

endpackage

// File: rtl/spi_debug_tx_if.sv
// Byte push handshake between the core (print port) and the SPI transmitter.
// Signals: in_valid (byte offered), in_data (byte), in_ready (FIFO has room).
// master = byte producer, slave = spi_debug_tx.
interface spi_debug_tx_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input  in_ready);
  modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/spi_debug_fifo.sv
// Synchronous byte FIFO, circular with naturally wrapping pointers.
// Ports: clk, rst_n (async active-low), push/din, pop/dout (dout shows head
// combinationally), full, empty, count. Push when full / pop when empty are ignored.
module spi_debug_fifo
  import spi_debug_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Full/empty come from the registered count only, so a pop in the same
  // cycle never opens room for a push.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spi_debug_tx.sv
// SPI mode-0 byte transmitter for the debug console (SCK on mprj_io[24], MOSI on mprj_io[25]).
// Ports: clk, rst_n (async active-low), in_if (byte push handshake), sck_o/mosi_o
// (registered pins), io_oeb_o (pad enables, always driven), busy_o (queued or shifting).
module spi_debug_tx
  import spi_debug_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CLK_DIV    = CLK_DIV_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  spi_debug_tx_if.slave       in_if,
  output logic                sck_o,
  output logic                mosi_o,
  output logic [1:0]          io_oeb_o,
  output logic                busy_o
);

  // Keep the counter at least one bit wide so CLK_DIV=1 still elaborates.
  localparam int                CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]     HALF_MAX = CW'(CLK_DIV - 1);

  state_t                     state;
  logic [CW-1:0]              half_cnt;
  logic [2:0]                 bit_idx;
  logic [7:0]                 shift_q;

  logic                       fifo_full;
  logic                       fifo_empty;
  logic [7:0]                 fifo_dout;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                       half_done;
  logic                       last_bit;
  logic                       pop;

  assign half_done = (half_cnt == HALF_MAX);
  assign last_bit  = (bit_idx == 3'd0);

  // Pop when starting from idle, or at the final falling edge of a byte so the
  // next byte follows with no gap in SCK.
  assign pop = !fifo_empty &&
               ((state == IDLE) || (state == HIGH && half_done && last_bit));

  spi_debug_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_if.in_valid),
    .din   (in_if.in_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign in_if.in_ready = !fifo_full;
  assign io_oeb_o       = 2'b00;
  assign busy_o         = (state != IDLE) || (fifo_count != '0);

  // Shift FSM. MOSI only ever changes together with SCK going (or staying) low,
  // so it is stable for a full half-period either side of every rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sck_o    <= 1'b0;
      mosi_o   <= 1'b0;
      shift_q  <= '0;
      bit_idx  <= '0;
      half_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          sck_o <= 1'b0;
          if (!fifo_empty) begin
            shift_q  <= fifo_dout;
            mosi_o   <= fifo_dout[7];
            bit_idx  <= 3'd7;
            half_cnt <= '0;
            state    <= LOW;
          end
        end

        LOW: begin
          if (half_done) begin
            sck_o    <= 1'b1;
            half_cnt <= '0;
            state    <= HIGH;
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end

        HIGH: begin
          if (half_done) begin
            sck_o    <= 1'b0;
            half_cnt <= '0;
            if (!last_bit) begin
              // shift_q keeps the current bit in [7]; the next one is in [6].
              bit_idx <= bit_idx - 1'b1;
              mosi_o  <= shift_q[6];
              shift_q <= {shift_q[6:0], 1'b0};
              state   <= LOW;
            end else if (!fifo_empty) begin
              shift_q <= fifo_dout;
              mosi_o  <= fifo_dout[7];
              bit_idx <= 3'd7;
              state   <= LOW;
            end else begin
              state <= IDLE;
            end
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end

        default: begin
          sck_o <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_debug_tx.sv
// Directed bench for spi_debug_tx: one instance at CLK_DIV=4, one at CLK_DIV=1.
// Posedge-counting receivers decode bytes and log SCK rise times.
module tb_spi_debug_tx;
  import spi_debug_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sck4, mosi4, busy4, sck1, mosi1, busy1;
  logic [1:0] oeb4, oeb1;
  int         cyc = 0;

  int checks   = 0;
  int failures = 0;

  spi_debug_tx_if if4 ();
  spi_debug_tx_if if1 ();

  spi_debug_tx #(.FIFO_DEPTH(8), .CLK_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_if(if4),
    .sck_o(sck4), .mosi_o(mosi4), .io_oeb_o(oeb4), .busy_o(busy4)
  );

  spi_debug_tx #(.FIFO_DEPTH(8), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_if(if1),
    .sck_o(sck1), .mosi_o(mosi1), .io_oeb_o(oeb1), .busy_o(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Receiver for the CLK_DIV=4 instance: outputs are sampled on the falling clk edge.
  logic       m4_sck_prev = 1'b0, m4_mosi_prev = 1'b0;
  logic [7:0] m4_sh = '0;
  int         m4_bits = 0, m4_rises = 0, m4_nrx = 0;
  int         m4_rise_cyc [0:511];
  logic [7:0] m4_rx [0:63];

  always @(negedge clk) begin
    if (!rst_n) begin
      m4_bits <= 0;
    end else if (sck4 && !m4_sck_prev) begin
      m4_rise_cyc[m4_rises] <= cyc;
      m4_rises <= m4_rises + 1;
      m4_sh    <= {m4_sh[6:0], mosi4};
      if (m4_bits == 7) begin
        m4_rx[m4_nrx] <= {m4_sh[6:0], mosi4};
        m4_nrx  <= m4_nrx + 1;
        m4_bits <= 0;
      end else begin
        m4_bits <= m4_bits + 1;
      end
    end
    m4_sck_prev  <= sck4;
    m4_mosi_prev <= mosi4;
  end

  // Receiver for the CLK_DIV=1 instance, also counting MOSI changes on rise cycles.
  logic       m1_sck_prev = 1'b0, m1_mosi_prev = 1'b0;
  logic [7:0] m1_sh = '0;
  int         m1_bits = 0, m1_rises = 0, m1_nrx = 0, m1_viol = 0;
  int         m1_rise_cyc [0:511];
  logic [7:0] m1_rx [0:63];

  always @(negedge clk) begin
    if (!rst_n) begin
      m1_bits <= 0;
    end else if (sck1 && !m1_sck_prev) begin
      m1_rise_cyc[m1_rises] <= cyc;
      m1_rises <= m1_rises + 1;
      if (mosi1 !== m1_mosi_prev) m1_viol <= m1_viol + 1;
      m1_sh <= {m1_sh[6:0], mosi1};
      if (m1_bits == 7) begin
        m1_rx[m1_nrx] <= {m1_sh[6:0], mosi1};
        m1_nrx  <= m1_nrx + 1;
        m1_bits <= 0;
      end else begin
        m1_bits <= m1_bits + 1;
      end
    end
    m1_sck_prev  <= sck1;
    m1_mosi_prev <= mosi1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) until busy drops; returns the cyc value at that point.
  task automatic wait_idle4(input int limit, output int idle_cyc);
    int n = 0;
    while (busy4 && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle4_timeout", {31'd0, busy4}, 32'd0);
    idle_cyc = cyc;
  endtask

  int tp, t_idle, r0, b0, bad, k, acc_at_full, n, c_sck, c_busy, c_nrdy;
  logic rdy;

  initial begin
    rst_n = 1'b0;
    if4.in_valid = 1'b0; if4.in_data = 8'h00;
    if1.in_valid = 1'b0; if1.in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sck_asserted", {31'd0, sck4}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", {31'd0, if4.in_ready}, 32'd1);
    chk("rst_sck",      {31'd0, sck4},         32'd0);
    chk("rst_mosi",     {31'd0, mosi4},        32'd0);
    chk("rst_busy",     {31'd0, busy4},        32'd0);
    chk("rst_oeb",      {30'd0, oeb4},         32'd0);

    // 1: single byte 0x41
    r0 = m4_rises; b0 = m4_nrx;
    @(negedge clk);
    if4.in_valid = 1'b1; if4.in_data = 8'h41;
    @(posedge clk); #1;
    tp = cyc;
    @(negedge clk);
    if4.in_valid = 1'b0;
    wait_idle4(400, t_idle);
    chk("t1_rises",      m4_rises - r0,            32'd8);
    chk("t1_bytes",      m4_nrx - b0,              32'd1);
    chk("t1_data",       {24'd0, m4_rx[b0]},       32'h41);
    chk("t1_first_rise", m4_rise_cyc[r0] - tp,     32'd5);
    chk("t1_busy_fall",  t_idle - m4_rise_cyc[r0+7], 32'd4);
    chk("t1_sck_idle",   {31'd0, sck4},            32'd0);

    // 2: "Hi\n" back to back
    r0 = m4_rises; b0 = m4_nrx;
    @(negedge clk); if4.in_valid = 1'b1; if4.in_data = 8'h48;
    @(negedge clk); if4.in_data = 8'h69;
    @(negedge clk); if4.in_data = 8'h0A;
    @(negedge clk); if4.in_valid = 1'b0;
    wait_idle4(1000, t_idle);
    chk("t2_rises", m4_rises - r0, 32'd24);
    chk("t2_bytes", m4_nrx - b0,   32'd3);
    chk("t2_b0",    {24'd0, m4_rx[b0]},   32'h48);
    chk("t2_b1",    {24'd0, m4_rx[b0+1]}, 32'h69);
    chk("t2_b2",    {24'd0, m4_rx[b0+2]}, 32'h0A);
    bad = 0;
    for (int i = 1; i < 24; i++)
      if (m4_rise_cyc[r0+i] - m4_rise_cyc[r0+i-1] != 8) bad++;
    chk("t2_period", bad, 32'd0);

    // 3: backpressure with 12 bytes
    r0 = m4_rises; b0 = m4_nrx;
    k = 0; acc_at_full = -1; n = 0;
    @(negedge clk);
    if4.in_valid = 1'b1;
    while (k < 12 && n < 3000) begin
      if4.in_data = 8'h30 + 8'(k);
      rdy = if4.in_ready;
      if (!rdy && acc_at_full < 0) acc_at_full = k;
      @(posedge clk);
      if (rdy) k++;
      @(negedge clk);
      n++;
    end
    if4.in_valid = 1'b0;
    chk("t3_accepted",     k,           32'd12);
    chk("t3_full_at",      acc_at_full, 32'd9);
    wait_idle4(3000, t_idle);
    chk("t3_bytes", m4_nrx - b0, 32'd12);
    bad = 0;
    for (int i = 0; i < 12; i++)
      if (m4_rx[b0+i] !== 8'h30 + 8'(i)) bad++;
    chk("t3_order", bad, 32'd0);

    // 4: reset mid-byte of 0xFF after the 3rd rise
    r0 = m4_rises;
    @(negedge clk); if4.in_valid = 1'b1; if4.in_data = 8'hFF;
    @(negedge clk); if4.in_valid = 1'b0;
    n = 0;
    while (m4_rises - r0 < 3 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t4_three_rises", m4_rises - r0, 32'd3);
    chk("t4_sck_high",    {31'd0, sck4}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t4_sck",      {31'd0, sck4},         32'd0);
    chk("t4_mosi",     {31'd0, mosi4},        32'd0);
    chk("t4_in_ready", {31'd0, if4.in_ready}, 32'd1);
    chk("t4_busy",     {31'd0, busy4},        32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    r0 = m4_rises; c_sck = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (sck4 !== 1'b0) c_sck++;
    end
    chk("t4_quiet_rises", m4_rises - r0, 32'd0);
    chk("t4_quiet_sck",   c_sck,         32'd0);

    // 5: CLK_DIV=1, 0xA5
    r0 = m1_rises; b0 = m1_nrx;
    @(negedge clk); if1.in_valid = 1'b1; if1.in_data = 8'hA5;
    @(negedge clk); if1.in_valid = 1'b0;
    n = 0;
    while (busy1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t5_idle",  {31'd0, busy1},      32'd0);
    chk("t5_rises", m1_rises - r0,       32'd8);
    chk("t5_data",  {24'd0, m1_rx[b0]},  32'hA5);
    bad = 0;
    for (int i = 1; i < 8; i++)
      if (m1_rise_cyc[r0+i] - m1_rise_cyc[r0+i-1] != 2) bad++;
    chk("t5_period",   bad,     32'd0);
    chk("t5_mosi_hold", m1_viol, 32'd0);

    // 6: idle quiet for 1000 cycles
    c_sck = 0; c_busy = 0; c_nrdy = 0;
    repeat (1000) begin
      @(posedge clk); #1;
      if (sck4 !== 1'b0 || sck1 !== 1'b0) c_sck++;
      if (busy4 !== 1'b0 || busy1 !== 1'b0) c_busy++;
      if (if4.in_ready !== 1'b1 || if1.in_ready !== 1'b1) c_nrdy++;
    end
    chk("t6_sck",      c_sck,  32'd0);
    chk("t6_busy",     c_busy, 32'd0);
    chk("t6_in_ready", c_nrdy, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_debug_tx.md
# spi_debug_tx

Byte-stream SPI transmitter in the user project that drives the debug console pins: SCK on `mprj_io[24]`, MOSI on `mprj_io[25]`. Bytes written by the core (e.g. a memory-mapped print port) are buffered in a small FIFO and shifted out MSB-first as SPI mode 0 (SCK idle low, data stable across the rising edge). The far end frames bytes by counting rising SCK edges only; there is no chip select. This block must therefore never emit a spurious or partial rising edge.

## Interface

Parameters:
- `FIFO_DEPTH`, default 8: byte FIFO entries. Power of two, at least 2.
- `CLK_DIV`, default 4: clk cycles per SCK half-period. At least 1.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: byte offered.
- `in_data` in 8: byte to transmit.
- `in_ready` out 1: FIFO can accept a byte.
- `sck_o` out 1: SPI clock, to `mprj_io[24]`.
- `mosi_o` out 1: SPI data, to `mprj_io[25]`.
- `io_oeb_o` out 2: pad output-enable bar for {MOSI, SCK}. Constant 2'b00.
- `busy_o` out 1: FIFO non-empty or shift in progress.

## Operation

- **Push:** a byte is accepted on a clk edge with `in_valid && in_ready`. `in_ready = !full`, derived from registered count only and not from same-cycle pop. When full, a push is not accepted even if a pop occurs in the same cycle.
- **FIFO:** circular, read/write pointers of log2(FIFO_DEPTH) bits wrap naturally, count of log2(FIFO_DEPTH)+1 bits.
- **States:** IDLE, LOW, HIGH.
  - IDLE: `sck_o` = 0, `mosi_o` holds its last value. If the FIFO is non-empty, pop into shift reg, drive `mosi_o` = bit 7, set bit index to 7, half-counter to 0, and go to LOW.
  - LOW: `sck_o` = 0. When the half-counter reaches CLK_DIV-1, go to HIGH with `sck_o` = 1 and reset the counter.
  - HIGH: `sck_o` = 1. When the counter reaches CLK_DIV-1:
    - `sck_o` goes to 0.
    - If bit index > 0: decrement it, drive the next bit on `mosi_o`, go to LOW.
    - Else if the FIFO is non-empty: pop the next byte, drive its bit 7, go to LOW. No gap between bytes.
    - Else go to IDLE.
- **Registered outputs:** `sck_o` and `mosi_o` are registers, with no combinational path to pins.
- **busy_o:** equals (state != IDLE) || count != 0.
- **Reset:** async assert forces IDLE, `sck_o` = 0, `mosi_o` = 0, and empties the FIFO. This holds mid-byte as well. A reset mid-byte desynchronises the receiver's bit count; this is accepted, and system reset resets both ends.

## Timing

- **Reset values:** `in_ready` = 1, `sck_o` = 0, `mosi_o` = 0, `busy_o` = 0, `io_oeb_o` = 0.
- **Push to first bit:** byte pushed into an empty FIFO at edge T. It is popped at T+1, so `mosi_o` shows bit 7 from T+1. First SCK rise at T+1+CLK_DIV.
- **Bit time:** each bit occupies 2·CLK_DIV cycles, and MOSI changes only on SCK falling-edge cycles.
  - Setup of MOSI before SCK rise: CLK_DIV cycles.
  - Hold of MOSI after SCK rise: CLK_DIV cycles.
- **Byte time:** 16·CLK_DIV cycles. Back-to-back bytes give continuous SCK with no stretched phase.
- **Throughput:** one byte per 16·CLK_DIV cycles. The FIFO absorbs bursts up to FIFO_DEPTH, plus the byte in the shift register.

## Structure

- **Package `spi_debug_pkg`:** state enum (IDLE, LOW, HIGH) and the default CLK_DIV constant.
- **Sub-module `spi_debug_fifo`:** the synchronous byte FIFO.
  - Parameter: DEPTH.
  - Ports: push/pop/din/dout/full/empty/count, with async active-low reset.
- **Top level:** the shift FSM, half-period counter and bit index live in `spi_debug_tx`.

## Test plan

1. **Single byte:** CLK_DIV=4, push 0x41 once.
   - Exactly 8 SCK rising edges.
   - MOSI sampled at the rises = 0,1,0,0,0,0,0,1.
   - First rise 5 cycles after the push edge.
   - `busy_o` falls after the 8th falling edge.
2. **Back-to-back:** push "Hi\n" (0x48, 0x69, 0x0A) in consecutive cycles.
   - A bench receiver counting posedges decodes exactly those three bytes.
   - SCK period stays constant at 8 cycles across byte boundaries.
3. **Backpressure:** FIFO_DEPTH=8, hold `in_valid` with 12 distinct bytes.
   - `in_ready` drops once 8 bytes are queued (9 accepted counting the byte popped into the shifter).
   - Remaining bytes are accepted as space frees.
   - All 12 bytes arrive in order with no loss or duplication.
4. **Reset mid-byte:** assert `rst_n` low after the 3rd rising edge of 0xFF.
   - `sck_o` = 0 and `mosi_o` = 0 in the same timestep.
   - FIFO empty, `in_ready` = 1.
   - After release, with no push, no SCK edges occur for 200 cycles.
5. **Minimum divider:** CLK_DIV=1, push 0xA5.
   - SCK toggles every cycle.
   - Decoded byte is 0xA5.
   - MOSI is never observed changing in the same cycle as an SCK rise.
6. **Idle quiet:** 1000 cycles with `in_valid` = 0.
   - `sck_o` constant 0.
   - `busy_o` = 0.
   - `in_ready` = 1.
